// File: rtl/stripe_feeder.sv
// stripe_feeder
// Parses a word stream into two kinds of packets and presents them to the
// stripe chain:
//   DESC (header type 1): instruction in the header, then tagA, tagB,
//        strideA, strideB, iter_count, iter_lim. Held on desc_valid until
//        desc_ready is sampled high.
//   DATA (header type 2): btagA, btagB, 8 d0 lanes, 8 d1 lanes. Broadcast
//        with a single-cycle bcast_valid pulse.
// Headers of any other type are dropped and set the sticky err flag.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_word  input word stream
//   desc_valid/desc_ready      descriptor handshake
//   instr_OUT .. iter_lim_OUT  descriptor fields
//   bcast_valid                one-cycle operand broadcast strobe
//   btagA_OUT, btagB_OUT       broadcast operand tags
//   d0_OUT, d1_OUT             operand blocks, lane k at [k*data_width +: data_width]
//   pkt_count                  completed packets, wrapping 16-bit counter
//   err                        sticky bad-header flag
//
// State      | meaning
// IDLE       | waiting for a header word
// DESC_BODY  | collecting the 6 descriptor words (cnt 0..5)
// DATA_TAG   | collecting btagA, btagB (cnt 0..1)
// DATA_BLK   | collecting d0 lanes 0..7 then d1 lanes 0..7 (cnt 0..15)
// HOLD_DESC  | descriptor presented, waiting for desc_ready
// EMIT       | bcast_valid cycle

module stripe_feeder #(
    parameter int data_width  = 16,
    parameter int tag_width   = 16,
    parameter int instr_width = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   in_word,
    output logic                    desc_valid,
    input  logic                    desc_ready,
    output logic [instr_width-1:0]  instr_OUT,
    output logic [tag_width-1:0]    tagA_OUT,
    output logic [tag_width-1:0]    tagB_OUT,
    output logic [tag_width-1:0]    strideA_OUT,
    output logic [tag_width-1:0]    strideB_OUT,
    output logic [tag_width-1:0]    iter_count_OUT,
    output logic [tag_width-1:0]    iter_lim_OUT,
    output logic                    bcast_valid,
    output logic [tag_width-1:0]    btagA_OUT,
    output logic [tag_width-1:0]    btagB_OUT,
    output logic [8*data_width-1:0] d0_OUT,
    output logic [8*data_width-1:0] d1_OUT,
    output logic [15:0]             pkt_count,
    output logic                    err
);

    typedef enum logic [2:0] {
        IDLE,
        DESC_BODY,
        DATA_TAG,
        DATA_BLK,
        HOLD_DESC,
        EMIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic [3:0] hdr_type;
    logic       bad_hdr;
    logic       pkt_done;

    assign hdr_type = in_word[15:12];
    assign accept   = in_valid & in_ready;
    assign bad_hdr  = (hdr_type != 4'd1) && (hdr_type != 4'd2);
    assign pkt_done = ((state == HOLD_DESC) && desc_ready) || (state == EMIT);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        in_ready    = 1'b0;
        desc_valid  = 1'b0;
        bcast_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    cnt_nxt = 4'd0;
                    if (hdr_type == 4'd1)
                        state_nxt = DESC_BODY;
                    else if (hdr_type == 4'd2)
                        state_nxt = DATA_TAG;
                end
            end
            DESC_BODY: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (cnt == 4'd5) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = HOLD_DESC;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            DATA_TAG: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (cnt == 4'd1) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = DATA_BLK;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            DATA_BLK: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (cnt == 4'd15) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = EMIT;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            HOLD_DESC: begin
                desc_valid = 1'b1;
                if (desc_ready)
                    state_nxt = IDLE;
            end
            EMIT: begin
                bcast_valid = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        // No word may be taken in the cycle where reset is sampled.
        if (rst)
            in_ready = 1'b0;
    end

    // Field outputs are written as their words arrive; the valid flags stay
    // low until the whole packet is in, so partial updates are never offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            instr_OUT      <= '0;
            tagA_OUT       <= '0;
            tagB_OUT       <= '0;
            strideA_OUT    <= '0;
            strideB_OUT    <= '0;
            iter_count_OUT <= '0;
            iter_lim_OUT   <= '0;
            btagA_OUT      <= '0;
            btagB_OUT      <= '0;
            d0_OUT         <= '0;
            d1_OUT         <= '0;
            pkt_count      <= 16'd0;
            err            <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (hdr_type == 4'd1)
                            instr_OUT <= instr_width'(in_word);
                        if (bad_hdr)
                            err <= 1'b1;
                    end
                    DESC_BODY: begin
                        case (cnt)
                            4'd0:    tagA_OUT       <= tag_width'(in_word);
                            4'd1:    tagB_OUT       <= tag_width'(in_word);
                            4'd2:    strideA_OUT    <= tag_width'(in_word);
                            4'd3:    strideB_OUT    <= tag_width'(in_word);
                            4'd4:    iter_count_OUT <= tag_width'(in_word);
                            default: iter_lim_OUT   <= tag_width'(in_word);
                        endcase
                    end
                    DATA_TAG: begin
                        if (cnt == 4'd0)
                            btagA_OUT <= tag_width'(in_word);
                        else
                            btagB_OUT <= tag_width'(in_word);
                    end
                    DATA_BLK: begin
                        // cnt[3] selects the block, cnt[2:0] the lane.
                        if (!cnt[3])
                            d0_OUT[cnt[2:0]*data_width +: data_width] <= in_word;
                        else
                            d1_OUT[cnt[2:0]*data_width +: data_width] <= in_word;
                    end
                    default: ;
                endcase
            end
            if (pkt_done)
                pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_stripe_feeder.sv
module tb_stripe_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_word;
    logic         desc_valid;
    logic         desc_ready;
    logic [6:0]   instr_OUT;
    logic [15:0]  tagA_OUT, tagB_OUT, strideA_OUT, strideB_OUT;
    logic [15:0]  iter_count_OUT, iter_lim_OUT;
    logic         bcast_valid;
    logic [15:0]  btagA_OUT, btagB_OUT;
    logic [127:0] d0_OUT, d1_OUT;
    logic [15:0]  pkt_count;
    logic         err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bpulses  = 0;
    int dpulses  = 0;

    stripe_feeder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .instr_OUT(instr_OUT), .tagA_OUT(tagA_OUT), .tagB_OUT(tagB_OUT),
        .strideA_OUT(strideA_OUT), .strideB_OUT(strideB_OUT),
        .iter_count_OUT(iter_count_OUT), .iter_lim_OUT(iter_lim_OUT),
        .bcast_valid(bcast_valid), .btagA_OUT(btagA_OUT), .btagB_OUT(btagB_OUT),
        .d0_OUT(d0_OUT), .d1_OUT(d1_OUT),
        .pkt_count(pkt_count), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bcast_valid) bpulses++;
        if (desc_valid)  dpulses++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        in_word  = w;
        while (!in_ready && waitc < 50) begin
            step();
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_word_timeout word=%h in_ready=%b required=1", w, in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_desc(input logic [15:0] hdr, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] sa, input logic [15:0] sb,
                             input logic [15:0] ic, input logic [15:0] il);
        send_word(hdr);
        send_word(a);
        send_word(b);
        send_word(sa);
        send_word(sb);
        send_word(ic);
        send_word(il);
    endtask

    task automatic send_data(input logic [15:0] ba, input logic [15:0] bb,
                             input logic [15:0] b0, input logic [15:0] b1, input int gap_at);
        logic [15:0] w;
        for (int i = 0; i < 19; i++) begin
            if (i == 0)      w = 16'h2000;
            else if (i == 1) w = ba;
            else if (i == 2) w = bb;
            else if (i < 11) w = b0 + 16'(i - 3);
            else             w = b1 + 16'(i - 11);
            send_word(w);
            if (i == gap_at) begin
                step();
                step();
                step();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_word = 16'h0; desc_ready = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        rst = 1'b0;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (desc_valid !== 1'b0) begin failures++; $display("FAIL reset_desc_valid got=%b exp=0", desc_valid); end
        checks++; if (bcast_valid !== 1'b0) begin failures++; $display("FAIL reset_bcast_valid got=%b exp=0", bcast_valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (pkt_count !== 16'h0) begin failures++; $display("FAIL reset_pkt_count got=%h exp=0", pkt_count); end
        checks++; if (tagA_OUT !== 16'h0 || instr_OUT !== 7'h0 || iter_lim_OUT !== 16'h0) begin
            failures++; $display("FAIL reset_desc_fields tagA=%h instr=%h lim=%h exp=0", tagA_OUT, instr_OUT, iter_lim_OUT); end
        checks++; if (d0_OUT !== 128'h0 || d1_OUT !== 128'h0 || btagA_OUT !== 16'h0) begin
            failures++; $display("FAIL reset_bcast_fields d0=%h d1=%h btagA=%h exp=0", d0_OUT, d1_OUT, btagA_OUT); end
    endtask

    task automatic test_desc();
        int p0;
        p0 = dpulses;
        desc_ready = 1'b1;
        send_desc(16'h1025, 16'h0010, 16'h0020, 16'h0001, 16'h0002, 16'h0000, 16'h0004);
        checks++; if (desc_valid !== 1'b1) begin failures++; $display("FAIL desc_valid_after_last got=%b exp=1", desc_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL desc_hold_in_ready got=%b exp=0", in_ready); end
        checks++; if (instr_OUT !== 7'h25) begin failures++; $display("FAIL desc_instr got=%h exp=25", instr_OUT); end
        checks++; if (tagA_OUT !== 16'h0010 || tagB_OUT !== 16'h0020) begin
            failures++; $display("FAIL desc_tags got=%h,%h exp=0010,0020", tagA_OUT, tagB_OUT); end
        checks++; if (strideA_OUT !== 16'h0001 || strideB_OUT !== 16'h0002) begin
            failures++; $display("FAIL desc_strides got=%h,%h exp=0001,0002", strideA_OUT, strideB_OUT); end
        checks++; if (iter_count_OUT !== 16'h0000 || iter_lim_OUT !== 16'h0004) begin
            failures++; $display("FAIL desc_iter got=%h,%h exp=0000,0004", iter_count_OUT, iter_lim_OUT); end
        step();
        checks++; if (desc_valid !== 1'b0) begin failures++; $display("FAIL desc_valid_drop got=%b exp=0", desc_valid); end
        checks++; if (pkt_count !== 16'd1) begin failures++; $display("FAIL desc_pkt_count got=%0d exp=1", pkt_count); end
        checks++; if (dpulses - p0 !== 1) begin failures++; $display("FAIL desc_pulse_len got=%0d exp=1", dpulses - p0); end
        checks++; if (tagA_OUT !== 16'h0010) begin failures++; $display("FAIL desc_field_kept got=%h exp=0010", tagA_OUT); end
    endtask

    task automatic test_desc_hold();
        desc_ready = 1'b0;
        send_desc(16'h1025, 16'h0010, 16'h0020, 16'h0001, 16'h0002, 16'h0000, 16'h0004);
        for (int i = 0; i < 5; i++) begin
            checks++; if (desc_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++; $display("FAIL hold_c%0d desc_valid=%b in_ready=%b exp=1,0", i, desc_valid, in_ready); end
            checks++; if (tagB_OUT !== 16'h0020 || iter_lim_OUT !== 16'h0004) begin
                failures++; $display("FAIL hold_fields_c%0d got=%h,%h exp=0020,0004", i, tagB_OUT, iter_lim_OUT); end
            step();
        end
        desc_ready = 1'b1;
        checks++; if (desc_valid !== 1'b1) begin failures++; $display("FAIL hold_before_ready got=%b exp=1", desc_valid); end
        step();
        desc_ready = 1'b0;
        checks++; if (desc_valid !== 1'b0) begin failures++; $display("FAIL hold_drop got=%b exp=0", desc_valid); end
        checks++; if (pkt_count !== 16'd2) begin failures++; $display("FAIL hold_pkt_count got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_data();
        int p0;
        p0 = bpulses;
        send_data(16'h0010, 16'h0020, 16'h0000, 16'h0100, 5);
        checks++; if (bcast_valid !== 1'b1) begin failures++; $display("FAIL data_bcast_valid got=%b exp=1", bcast_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL data_emit_in_ready got=%b exp=0", in_ready); end
        checks++; if (btagA_OUT !== 16'h0010 || btagB_OUT !== 16'h0020) begin
            failures++; $display("FAIL data_btags got=%h,%h exp=0010,0020", btagA_OUT, btagB_OUT); end
        checks++; if (d0_OUT[15:0] !== 16'h0000 || d0_OUT[127:112] !== 16'h0007 || d0_OUT[63:48] !== 16'h0003) begin
            failures++; $display("FAIL data_d0 got=%h exp lane0=0 lane3=3 lane7=7", d0_OUT); end
        checks++; if (d1_OUT[15:0] !== 16'h0100 || d1_OUT[127:112] !== 16'h0107) begin
            failures++; $display("FAIL data_d1 got=%h exp lane0=0100 lane7=0107", d1_OUT); end
        checks++; if (tagA_OUT !== 16'h0010 || instr_OUT !== 7'h25 || desc_valid !== 1'b0) begin
            failures++; $display("FAIL data_desc_untouched tagA=%h instr=%h dv=%b exp=0010,25,0", tagA_OUT, instr_OUT, desc_valid); end
        step();
        checks++; if (bcast_valid !== 1'b0) begin failures++; $display("FAIL data_bcast_drop got=%b exp=0", bcast_valid); end
        checks++; if (bpulses - p0 !== 1) begin failures++; $display("FAIL data_pulse_count got=%0d exp=1", bpulses - p0); end
        checks++; if (pkt_count !== 16'd3) begin failures++; $display("FAIL data_pkt_count got=%0d exp=3", pkt_count); end
        checks++; if (d1_OUT[127:112] !== 16'h0107) begin failures++; $display("FAIL data_field_kept got=%h exp=0107", d1_OUT[127:112]); end
    endtask

    task automatic test_bad_header();
        send_word(16'h3000);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_hdr_err got=%b exp=1", err); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bad_hdr_idle got=%b exp=1", in_ready); end
        desc_ready = 1'b1;
        send_desc(16'h1033, 16'h00A1, 16'h00A2, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
        checks++; if (desc_valid !== 1'b1 || instr_OUT !== 7'h33 || tagA_OUT !== 16'h00A1) begin
            failures++; $display("FAIL bad_hdr_desc dv=%b instr=%h tagA=%h exp=1,33,00A1", desc_valid, instr_OUT, tagA_OUT); end
        checks++; if (btagA_OUT !== 16'h0010 || d0_OUT[127:112] !== 16'h0007) begin
            failures++; $display("FAIL desc_bcast_untouched btagA=%h lane7=%h exp=0010,0007", btagA_OUT, d0_OUT[127:112]); end
        step();
        checks++; if (pkt_count !== 16'd4 || err !== 1'b1) begin
            failures++; $display("FAIL bad_hdr_done pkt=%0d err=%b exp=4,1", pkt_count, err); end
        step();
        step();
        step();
        desc_ready = 1'b0;
        checks++; if (pkt_count !== 16'd4 || desc_valid !== 1'b0) begin
            failures++; $display("FAIL idle_desc_ready pkt=%0d dv=%b exp=4,0", pkt_count, desc_valid); end
    endtask

    task automatic test_reset_mid_packet();
        int p0;
        send_word(16'h2000);
        send_word(16'h0055);
        send_word(16'h0066);
        for (int k = 0; k < 7; k++) send_word(16'h0400 + 16'(k));
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (err !== 1'b0 || pkt_count !== 16'h0) begin
            failures++; $display("FAIL rst_mid_state err=%b pkt=%0d exp=0,0", err, pkt_count); end
        checks++; if (d0_OUT !== 128'h0 || btagA_OUT !== 16'h0 || tagA_OUT !== 16'h0) begin
            failures++; $display("FAIL rst_mid_fields d0=%h btagA=%h tagA=%h exp=0", d0_OUT, btagA_OUT, tagA_OUT); end
        p0 = bpulses;
        step();
        step();
        step();
        checks++; if (bpulses - p0 !== 0) begin failures++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", bpulses - p0); end
        send_data(16'h00AA, 16'h00BB, 16'h0200, 16'h0300, -1);
        checks++; if (bcast_valid !== 1'b1 || btagA_OUT !== 16'h00AA || btagB_OUT !== 16'h00BB) begin
            failures++; $display("FAIL rst_new_pkt bv=%b btags=%h,%h exp=1,00AA,00BB", bcast_valid, btagA_OUT, btagB_OUT); end
        checks++; if (d0_OUT[15:0] !== 16'h0200 || d0_OUT[111:96] !== 16'h0206 || d1_OUT[127:112] !== 16'h0307) begin
            failures++; $display("FAIL rst_new_lanes d0=%h d1=%h exp lane0=0200 lane6=0206 d1lane7=0307", d0_OUT, d1_OUT); end
        step();
        checks++; if (bpulses - p0 !== 1 || pkt_count !== 16'd1) begin
            failures++; $display("FAIL rst_new_count pulses=%0d pkt=%0d exp=1,1", bpulses - p0, pkt_count); end
    endtask

    task automatic test_back_to_back();
        int c0;
        desc_ready = 1'b1;
        c0 = cyc;
        send_desc(16'h1001, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
        send_desc(16'h1002, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016);
        checks++; if (cyc - c0 !== 15) begin failures++; $display("FAIL b2b_desc_cycles got=%0d exp=15", cyc - c0); end
        checks++; if (desc_valid !== 1'b1 || instr_OUT !== 7'h02 || iter_lim_OUT !== 16'h0016) begin
            failures++; $display("FAIL b2b_desc_fields dv=%b instr=%h lim=%h exp=1,02,0016", desc_valid, instr_OUT, iter_lim_OUT); end
        step();
        c0 = cyc;
        send_data(16'h0001, 16'h0002, 16'h0010, 16'h0020, -1);
        send_data(16'h0003, 16'h0004, 16'h0030, 16'h0040, -1);
        checks++; if (cyc - c0 !== 39) begin failures++; $display("FAIL b2b_data_cycles got=%0d exp=39", cyc - c0); end
        checks++; if (bcast_valid !== 1'b1 || btagA_OUT !== 16'h0003 || d1_OUT[127:112] !== 16'h0047) begin
            failures++; $display("FAIL b2b_data_fields bv=%b btagA=%h d1lane7=%h exp=1,0003,0047", bcast_valid, btagA_OUT, d1_OUT[127:112]); end
        step();
        desc_ready = 1'b0;
        checks++; if (pkt_count !== 16'd5) begin failures++; $display("FAIL b2b_pkt_count got=%0d exp=5", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_desc();
        test_desc_hold();
        test_data();
        test_bad_header();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
